data_req_arbiter: RTL

Arbitrates the single sram-like data-memory port between two requesters: m0, the pipeline load/store path, and m1, the cache-maintenance/uncached-buffer engine. It tracks accepted transactions in an in-order ID queue so each `data_data_ok`/`data_rdata` beat is routed back to its owner. It also supports per-requester cancel on pipeline flush, so responses belonging to flushed requests are swallowed rather than delivered. It sits between the pre_MEM/MEM stages (and the maintenance engine) and the data-side cache/AXI bridge.

---
 rtl/data_req_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/data_req_arbiter.sv
// Two-port arbiter for the data-side sram-like port with an in-order response ID queue and per-port flush cancel.
// Define DATA_ARB_RR_EN for round-robin grant; otherwise m0 has fixed priority.
module data_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,
    input  logic        m0_cancel,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,
    input  logic        m1_cancel,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [MAX_OUTSTANDING-1:0] ONE = 1;

    logic [CW-1:0]              count;
    logic [MAX_OUTSTANDING-1:0] q_id;
    logic [MAX_OUTSTANDING-1:0] q_dead;
    logic [MAX_OUTSTANDING-1:0] dead_mark, id_s, dead_s, wsel;
    logic [CW-1:0]              wp_idx;

    logic        locked, lock_id, lock_ghost, lock_wr;
    logic [1:0]  lock_size;
    logic [31:0] lock_addr, lock_wdata;

    logic [1:0] cancel;
    logic       req0_ok, req1_ok, pop, room, grant_id, cur_id, ghost, accept, head_dead;

    assign cancel  = {m1_cancel, m0_cancel};
    assign req0_ok = m0_req && !m0_cancel;
    assign req1_ok = m1_req && !m1_cancel;
    assign pop     = data_data_ok && (count != '0);
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign room    = (count < CW'(MAX_OUTSTANDING)) || pop;

`ifdef DATA_ARB_RR_EN
    logic prio;

    assign grant_id = (req0_ok && req1_ok) ? prio : req1_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (accept && !ghost) begin
            prio <= !cur_id;
        end
    end
`else
    assign grant_id = !req0_ok;
`endif

    assign cur_id = locked ? lock_id : grant_id;
    assign ghost  = locked && (lock_ghost || cancel[lock_id]);

    always_comb begin
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        if (locked) begin
            data_req   = 1'b1;
            data_wr    = lock_wr;
            data_size  = lock_size;
            data_addr  = lock_addr;
            data_wdata = lock_wdata;
        end else if (room && (req0_ok || req1_ok)) begin
            data_req   = 1'b1;
            data_wr    = grant_id ? m1_wr    : m0_wr;
            data_size  = grant_id ? m1_size  : m0_size;
            data_addr  = grant_id ? m1_addr  : m0_addr;
            data_wdata = grant_id ? m1_wdata : m0_wdata;
        end
    end

    assign accept     = data_req && data_addr_ok;
    assign m0_addr_ok = accept && !cur_id && !ghost;
    assign m1_addr_ok = accept &&  cur_id && !ghost;

    assign head_dead  = q_dead[0] || cancel[q_id[0]];
    assign m0_data_ok = pop && !q_id[0] && !head_dead;
    assign m1_data_ok = pop &&  q_id[0] && !head_dead;
    assign m0_rdata   = data_rdata;
    assign m1_rdata   = data_rdata;

    // Entry 0 is the queue head; cancels mark before the shift so a cancelled head is dropped on pop.
    assign dead_mark = q_dead | (q_id & {MAX_OUTSTANDING{m1_cancel}})
                              | (~q_id & {MAX_OUTSTANDING{m0_cancel}});
    assign id_s      = pop ? (q_id >> 1) : q_id;
    assign dead_s    = pop ? (dead_mark >> 1) : dead_mark;
    assign wp_idx    = count - CW'(pop);
    assign wsel      = accept ? (ONE << wp_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            q_id   <= '0;
            q_dead <= '0;
        end else begin
            count  <= count + CW'(accept) - CW'(pop);
            q_id   <= (id_s & ~wsel) | (wsel & {MAX_OUTSTANDING{cur_id}});
            q_dead <= (dead_s & ~wsel) | (wsel & {MAX_OUTSTANDING{ghost}});
        end
    end

    // A request that saw no addr_ok must be replayed unchanged, so its fields are held here.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked     <= 1'b0;
            lock_id    <= 1'b0;
            lock_ghost <= 1'b0;
            lock_wr    <= 1'b0;
            lock_size  <= 2'd0;
            lock_addr  <= 32'd0;
            lock_wdata <= 32'd0;
        end else if (locked) begin
            lock_ghost <= ghost;
            if (data_addr_ok) begin
                locked <= 1'b0;
            end
        end else if (data_req && !data_addr_ok) begin
            locked     <= 1'b1;
            lock_id    <= grant_id;
            lock_ghost <= 1'b0;
            lock_wr    <= data_wr;
            lock_size  <= data_size;
            lock_addr  <= data_addr;
            lock_wdata <= data_wdata;
        end
    end

`ifndef SYNTHESIS
    no_orphan_response: assert property (@(posedge clk) disable iff (reset)
        !(data_data_ok && count == '0));
`endif

endmodule
